// File: rtl/jellyvl_synctimer_pkg.sv
// Shared types and helpers for the multi-channel sync-timer core.
package jellyvl_synctimer_pkg;

    typedef enum logic [0:0] {
        IDLE,
        WAIT
    } adj_state_t;

    // Wide enough that any timer-width error and adjust bound sign-extend losslessly.
    localparam int unsigned CLIP_WIDTH = 128;

    function automatic logic signed [CLIP_WIDTH-1:0] clip_signed(
        input logic signed [CLIP_WIDTH-1:0] value,
        input logic signed [CLIP_WIDTH-1:0] lo,
        input logic signed [CLIP_WIDTH-1:0] hi
    );
        if (value < lo) begin
            return lo;
        end
        if (value > hi) begin
            return hi;
        end
        return value;
    endfunction

endpackage

// File: rtl/jellyvl_synctimer_frac_timer.sv
// Fractional-rate timer: advances NUMERATOR/DENOMINATOR units per clock, with
// absolute load and a +/-1 slew input.
module jellyvl_synctimer_frac_timer #(
    parameter int unsigned TIMER_WIDTH = 64,
    parameter int unsigned NUMERATOR   = 10,
    parameter int unsigned DENOMINATOR = 3
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_set,
    input  logic [TIMER_WIDTH-1:0] i_set_time,
    input  logic [1:0]             i_step,
    output logic [TIMER_WIDTH-1:0] o_time
);

    localparam int unsigned INC_INT   = NUMERATOR / DENOMINATOR;
    localparam int unsigned INC_REM   = NUMERATOR % DENOMINATOR;
    localparam int unsigned ACC_WIDTH = $clog2(DENOMINATOR + 1) + 1;

    logic [ACC_WIDTH-1:0]   r_acc;
    logic [TIMER_WIDTH-1:0] r_time;
    logic [ACC_WIDTH-1:0]   w_acc_sum;
    logic                   w_carry;
    logic [TIMER_WIDTH-1:0] w_inc;

    always_comb begin
        w_acc_sum = r_acc + ACC_WIDTH'(INC_REM);
        w_carry   = (w_acc_sum >= ACC_WIDTH'(DENOMINATOR));
        // i_step is two's complement in {-1,0,+1}; sign-extend into the increment.
        w_inc     = TIMER_WIDTH'(INC_INT) + TIMER_WIDTH'(w_carry)
                  + {{(TIMER_WIDTH-2){i_step[1]}}, i_step};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_time <= '0;
            r_acc  <= '0;
        end else if (i_set) begin
            r_time <= i_set_time;
            r_acc  <= '0;
        end else begin
            r_time <= r_time + w_inc;
            r_acc  <= w_carry ? (w_acc_sum - ACC_WIDTH'(DENOMINATOR)) : w_acc_sum;
        end
    end

    assign o_time = r_time;

endmodule

// File: rtl/jellyvl_synctimer_core_multi.sv
// Sync-timer core: fractional local timer disciplined by NUM_CH prioritised
// correction sources, with hard set / soft slew, lock detection and drop flags.
module jellyvl_synctimer_core_multi
    import jellyvl_synctimer_pkg::*;
#(
    parameter int unsigned TIMER_WIDTH     = 64,
    parameter int unsigned NUMERATOR       = 10,
    parameter int unsigned DENOMINATOR     = 3,
    parameter int unsigned NUM_CH          = 2,
    parameter int unsigned ADJ_ERROR_WIDTH = 32,
    parameter int unsigned ADJ_INTERVAL    = 16,
    parameter int unsigned LOCK_THRESH     = 4,
    parameter int unsigned LOCK_COUNT      = 8,
    localparam int unsigned CH_WIDTH       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic signed [TIMER_WIDTH-1:0]     i_param_limit_min,
    input  logic signed [TIMER_WIDTH-1:0]     i_param_limit_max,
    input  logic signed [ADJ_ERROR_WIDTH-1:0] i_param_adjust_min,
    input  logic signed [ADJ_ERROR_WIDTH-1:0] i_param_adjust_max,
    input  logic [TIMER_WIDTH-1:0]            i_set_time,
    input  logic                              i_set_valid,
    input  logic [NUM_CH-1:0]                 i_ch_enable,
    input  logic [NUM_CH-1:0]                 i_correct_override,
    input  logic [NUM_CH*TIMER_WIDTH-1:0]     i_correct_time,
    input  logic [NUM_CH-1:0]                 i_correct_valid,
    input  logic                              i_drop_clear,
    output logic [TIMER_WIDTH-1:0]            o_current_time,
    output logic [CH_WIDTH-1:0]               o_active_ch,
    output logic                              o_ch_valid,
    output logic signed [TIMER_WIDTH-1:0]     o_last_error,
    output logic                              o_locked,
    output logic [NUM_CH-1:0]                 o_drop
);

    localparam int unsigned CNT_WIDTH  = $clog2(ADJ_INTERVAL + 1);
    localparam int unsigned LOCK_WIDTH = $clog2(LOCK_COUNT + 1);

    adj_state_t                   r_state;
    adj_state_t                   w_state_next;
    logic signed [ADJ_ERROR_WIDTH-1:0] r_rem;
    logic signed [ADJ_ERROR_WIDTH-1:0] w_rem_next;
    logic signed [ADJ_ERROR_WIDTH-1:0] w_rem_load;
    logic [CNT_WIDTH-1:0]         r_cnt;
    logic [CNT_WIDTH-1:0]         w_cnt_next;
    logic                         r_init_flag;
    logic [LOCK_WIDTH-1:0]        r_lock_cnt;
    logic [LOCK_WIDTH-1:0]        w_lock_cnt_next;
    logic [LOCK_WIDTH-1:0]        w_lock_cnt_inc;
    logic                         r_locked;
    logic                         w_locked_next;
    logic signed [TIMER_WIDTH-1:0] r_last_error;
    logic [NUM_CH-1:0]            r_drop;
    logic [CH_WIDTH-1:0]          r_active_ch;
    logic                         r_ch_valid;

    logic [NUM_CH-1:0]            w_req;
    logic [NUM_CH-1:0]            w_win;
    logic [NUM_CH-1:0]            w_drop_set;
    logic [CH_WIDTH-1:0]          w_sel;
    logic [TIMER_WIDTH-1:0]       w_sel_time;
    logic                         w_sel_ovr;
    logic                         w_accept;
    logic [TIMER_WIDTH-1:0]       w_time;
    logic signed [TIMER_WIDTH-1:0] w_err;
    logic [TIMER_WIDTH-1:0]       w_abs_err;
    logic                         w_in_thresh;
    logic                         w_out_of_limit;
    logic                         w_hard_ch;
    logic                         w_hard;
    logic                         w_soft;
    logic [TIMER_WIDTH-1:0]       w_set_time;
    logic [1:0]                   w_step;

    // Arbitration: lowest-index valid & enabled channel wins.
    always_comb begin
        w_req      = i_correct_valid & i_ch_enable;
        w_sel      = '0;
        w_sel_time = '0;
        w_sel_ovr  = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_sel      = CH_WIDTH'(i);
                w_sel_time = i_correct_time[i*TIMER_WIDTH +: TIMER_WIDTH];
                w_sel_ovr  = i_correct_override[i];
            end
        end
        w_win      = w_req & (~w_req + NUM_CH'(1));
        w_accept   = (|w_req) && !i_set_valid;
        w_drop_set = i_set_valid ? '0 : (w_req & ~w_win);
    end

    always_comb begin
        w_err          = $signed(w_sel_time - w_time);
        w_abs_err      = w_err[TIMER_WIDTH-1] ? TIMER_WIDTH'(-w_err) : TIMER_WIDTH'(w_err);
        w_in_thresh    = (w_abs_err <= TIMER_WIDTH'(LOCK_THRESH));
        w_out_of_limit = (w_err < i_param_limit_min) || (w_err > i_param_limit_max);
        w_hard_ch      = w_accept && (w_sel_ovr || r_init_flag || w_out_of_limit);
        w_hard         = i_set_valid || w_hard_ch;
        w_soft         = w_accept && !w_hard_ch;
        w_set_time     = i_set_valid ? i_set_time : w_sel_time;
        w_rem_load     = ADJ_ERROR_WIDTH'(clip_signed(CLIP_WIDTH'(w_err),
                                                      CLIP_WIDTH'(i_param_adjust_min),
                                                      CLIP_WIDTH'(i_param_adjust_max)));
    end

    // Step FSM: a soft load restarts the interval; one +/-1 step per interval.
    always_comb begin
        w_state_next = r_state;
        w_rem_next   = r_rem;
        w_cnt_next   = r_cnt;
        w_step       = 2'b00;
        if (w_hard) begin
            w_state_next = IDLE;
            w_rem_next   = '0;
            w_cnt_next   = '0;
        end else if (w_soft) begin
            w_rem_next   = w_rem_load;
            w_cnt_next   = '0;
            w_state_next = (w_rem_load != '0) ? WAIT : IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_cnt_next = '0;
                end
                WAIT: begin
                    if (r_cnt == CNT_WIDTH'(ADJ_INTERVAL - 1)) begin
                        w_step     = r_rem[ADJ_ERROR_WIDTH-1] ? 2'b11 : 2'b01;
                        w_rem_next = r_rem[ADJ_ERROR_WIDTH-1] ? (r_rem + ADJ_ERROR_WIDTH'(1))
                                                              : (r_rem - ADJ_ERROR_WIDTH'(1));
                        w_cnt_next = '0;
                        if (w_rem_next == '0) begin
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_cnt_next = r_cnt + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_lock_cnt_inc  = (r_lock_cnt == LOCK_WIDTH'(LOCK_COUNT)) ? r_lock_cnt
                                                                  : (r_lock_cnt + LOCK_WIDTH'(1));
        w_lock_cnt_next = r_lock_cnt;
        w_locked_next   = r_locked;
        if (w_hard) begin
            w_lock_cnt_next = '0;
            w_locked_next   = 1'b0;
        end else if (w_soft) begin
            if (w_in_thresh) begin
                w_lock_cnt_next = w_lock_cnt_inc;
                w_locked_next   = r_locked || (w_lock_cnt_inc == LOCK_WIDTH'(LOCK_COUNT));
            end else begin
                w_lock_cnt_next = '0;
                w_locked_next   = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_rem        <= '0;
            r_cnt        <= '0;
            r_init_flag  <= 1'b1;
            r_lock_cnt   <= '0;
            r_locked     <= 1'b0;
            r_last_error <= '0;
            r_drop       <= '0;
            r_active_ch  <= '0;
            r_ch_valid   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_rem      <= w_rem_next;
            r_cnt      <= w_cnt_next;
            r_lock_cnt <= w_lock_cnt_next;
            r_locked   <= w_locked_next;
            r_ch_valid <= w_accept;
            // A same-cycle drop event wins over drop_clear.
            r_drop     <= (r_drop & ~{NUM_CH{i_drop_clear}}) | w_drop_set;
            if (i_set_valid) begin
                r_init_flag <= 1'b1;
            end else if (w_hard_ch) begin
                r_init_flag <= 1'b0;
            end
            if (w_accept) begin
                r_last_error <= w_err;
                r_active_ch  <= w_sel;
            end
        end
    end

    jellyvl_synctimer_frac_timer #(
        .TIMER_WIDTH (TIMER_WIDTH),
        .NUMERATOR   (NUMERATOR),
        .DENOMINATOR (DENOMINATOR)
    ) u_frac_timer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_set      (w_hard),
        .i_set_time (w_set_time),
        .i_step     (w_step),
        .o_time     (w_time)
    );

    assign o_current_time = w_time;
    assign o_active_ch    = r_active_ch;
    assign o_ch_valid     = r_ch_valid;
    assign o_last_error   = r_last_error;
    assign o_locked       = r_locked;
    assign o_drop         = r_drop;

endmodule

// File: tb/tb_jellyvl_synctimer_core_multi.sv
// Self-checking bench: cycle-level reference model plus directed literal checks.
module tb_jellyvl_synctimer_core_multi;

    localparam int unsigned TW       = 64;
    localparam int unsigned AEW      = 32;
    localparam int unsigned NCH      = 2;
    localparam int unsigned NUM      = 10;
    localparam int unsigned DEN      = 3;
    localparam int unsigned INTERVAL = 16;
    localparam int unsigned THRESH   = 4;
    localparam int unsigned LCOUNT   = 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic signed [TW-1:0]  lim_min, lim_max;
    logic signed [AEW-1:0] adj_min, adj_max;
    logic [TW-1:0]         set_time;
    logic                  set_valid;
    logic [NCH-1:0]        cen, covr, cvalid;
    logic [NCH*TW-1:0]     ctime;
    logic                  dclear;
    logic [TW-1:0]         cur_time;
    logic [0:0]            active_ch;
    logic                  ch_valid;
    logic signed [TW-1:0]  last_error;
    logic                  locked;
    logic [NCH-1:0]        drop;

    always #5 clk = ~clk;

    jellyvl_synctimer_core_multi #(
        .TIMER_WIDTH     (TW),
        .NUMERATOR       (NUM),
        .DENOMINATOR     (DEN),
        .NUM_CH          (NCH),
        .ADJ_ERROR_WIDTH (AEW),
        .ADJ_INTERVAL    (INTERVAL),
        .LOCK_THRESH     (THRESH),
        .LOCK_COUNT      (LCOUNT)
    ) dut (
        .i_clk              (clk),
        .i_reset            (reset),
        .i_param_limit_min  (lim_min),
        .i_param_limit_max  (lim_max),
        .i_param_adjust_min (adj_min),
        .i_param_adjust_max (adj_max),
        .i_set_time         (set_time),
        .i_set_valid        (set_valid),
        .i_ch_enable        (cen),
        .i_correct_override (covr),
        .i_correct_time     (ctime),
        .i_correct_valid    (cvalid),
        .i_drop_clear       (dclear),
        .o_current_time     (cur_time),
        .o_active_ch        (active_ch),
        .o_ch_valid         (ch_valid),
        .o_last_error       (last_error),
        .o_locked           (locked),
        .o_drop             (drop)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: time = base + floor(n*NUM/DEN), n = clocks since last load.
    logic [63:0]        m_base;
    longint unsigned    m_n;
    logic signed [31:0] m_rem;
    int                 m_age;
    bit                 m_init;
    int                 m_lcnt;
    bit                 m_locked;
    logic [63:0]        m_lerr;
    logic [NCH-1:0]     m_drop;
    bit                 m_chv;
    bit                 m_ach;
    bit                 m_live = 1'b0;

    function automatic logic [63:0] model_now();
        return m_base + (m_n * NUM) / DEN;
    endfunction

    task automatic model_load(input logic [63:0] v);
        m_base   = v;
        m_n      = 0;
        m_rem    = 0;
        m_age    = 0;
        m_lcnt   = 0;
        m_locked = 1'b0;
    endtask

    always @(posedge clk) begin
        logic [63:0]        cur, ct, abs_e;
        logic signed [63:0] err, amin, amax;
        logic [NCH-1:0]     req;
        int                 sel;
        cur = model_now();
        if (reset) begin
            model_load(64'd0);
            m_init = 1'b1;
            m_lerr = '0;
            m_drop = '0;
            m_chv  = 1'b0;
            m_ach  = 1'b0;
            m_live = 1'b1;
        end else begin
            req = cvalid & cen;
            if (dclear) m_drop = '0;
            if (set_valid) begin
                model_load(set_time);
                m_init = 1'b1;
                m_chv  = 1'b0;
            end else if (req != '0) begin
                sel = 0;
                for (int i = NCH - 1; i >= 0; i--) if (req[i]) sel = i;
                for (int i = 0; i < NCH; i++) if (req[i] && i != sel) m_drop[i] = 1'b1;
                ct     = ctime[sel*TW +: TW];
                err    = $signed(ct - cur);
                m_lerr = err;
                m_chv  = 1'b1;
                m_ach  = sel[0];
                if (covr[sel] || m_init || err < lim_min || err > lim_max) begin
                    model_load(ct);
                    m_init = 1'b0;
                end else begin
                    amin  = adj_min;
                    amax  = adj_max;
                    m_rem = (err < amin) ? adj_min : (err > amax) ? adj_max : err[31:0];
                    m_age = 0;
                    m_n++;
                    abs_e = (err < 0) ? -err : err;
                    if (abs_e <= 64'(THRESH)) begin
                        if (m_lcnt < int'(LCOUNT)) m_lcnt++;
                        if (m_lcnt == int'(LCOUNT)) m_locked = 1'b1;
                    end else begin
                        m_lcnt   = 0;
                        m_locked = 1'b0;
                    end
                end
            end else begin
                m_chv = 1'b0;
                m_n++;
                if (m_rem != 0) begin
                    m_age++;
                    if (m_age == int'(INTERVAL)) begin
                        m_base = (m_rem > 0) ? m_base + 64'd1 : m_base - 64'd1;
                        m_rem  = (m_rem > 0) ? m_rem - 1 : m_rem + 1;
                        m_age  = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("model current_time", cur_time, model_now());
            chk("model last_error", last_error, m_lerr);
            chk("model locked", 64'(locked), 64'(m_locked));
            chk("model drop", 64'(drop), 64'(m_drop));
            chk("model ch_valid", 64'(ch_valid), 64'(m_chv));
            chk("model active_ch", 64'(active_ch), 64'(m_ach));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [NCH-1:0] v, input logic [63:0] t0, input logic [63:0] t1,
                        input logic [NCH-1:0] ovr);
        cvalid = v;
        ctime  = {t1, t0};
        covr   = ovr;
        tick(1);
        cvalid = '0;
        covr   = '0;
    endtask

    logic [63:0] ct;

    initial begin
        reset     = 1'b1;
        lim_min   = -64'sd1000;
        lim_max   = 64'sd1000;
        adj_min   = -32'sd1000;
        adj_max   = 32'sd1000;
        set_time  = '0;
        set_valid = 1'b0;
        cen       = 2'b11;
        covr      = '0;
        cvalid    = '0;
        ctime     = '0;
        dclear    = 1'b0;
        tick(2);
        chk("reset time", cur_time, 64'd0);
        chk("reset locked", 64'(locked), 64'd0);
        chk("reset drop", 64'(drop), 64'd0);
        reset = 1'b0;

        // Fractional rate 10/3 -> 3,3,4
        tick(1); chk("time 3", cur_time, 64'd3);
        tick(1); chk("time 6", cur_time, 64'd6);
        tick(1); chk("time 10", cur_time, 64'd10);
        tick(3); chk("time 20", cur_time, 64'd20);

        // First sample hard-sets via init flag
        send(2'b01, 64'd1000, 64'd0, 2'b00);
        chk("init hard time", cur_time, 64'd1000);
        chk("init last_error", last_error, 64'd980);
        chk("init ch_valid", 64'(ch_valid), 64'd1);

        // Soft +3: steps at 16-clock spacing
        send(2'b01, 64'd1003, 64'd0, 2'b00);
        chk("soft last_error", last_error, 64'd3);
        chk("soft time", cur_time, 64'd1003);
        tick(15); chk("before first step", cur_time, 64'd1053);
        tick(1);  chk("first step", cur_time, 64'd1057);
        tick(32); chk("third step", cur_time, 64'd1166);
        tick(16); chk("idle after steps", cur_time, 64'd1219);

        // Lock: out-of-threshold sample resets the count, then 8 in-threshold samples
        send(2'b01, model_now() + 64'd10, 64'd0, 2'b00);
        for (int k = 0; k < 8; k++) begin
            send(2'b01, model_now(), 64'd0, 2'b00);
            if (k == 6) chk("not yet locked", 64'(locked), 64'd0);
        end
        chk("locked", 64'(locked), 64'd1);

        // Arbitration and drop flags
        send(2'b11, model_now(), model_now() + 64'd7, 2'b00);
        chk("arb drop", 64'(drop), 64'b10);
        chk("arb active_ch", 64'(active_ch), 64'd0);
        dclear = 1'b1;
        send(2'b11, model_now(), model_now(), 2'b00);
        chk("drop set beats clear", 64'(drop), 64'b10);
        tick(1);
        dclear = 1'b0;
        chk("drop cleared", 64'(drop), 64'd0);
        send(2'b10, 64'd0, model_now(), 2'b00);
        chk("ch1 active", 64'(active_ch), 64'd1);
        cen = 2'b01;
        send(2'b11, model_now(), model_now(), 2'b00);
        chk("disabled no drop", 64'(drop), 64'd0);
        cen = 2'b11;

        // Out-of-limit hard set clears lock and remainder
        send(2'b01, model_now() + 64'd3, 64'd0, 2'b00);
        chk("still locked", 64'(locked), 64'd1);
        ct = model_now() + 64'd5000;
        send(2'b01, ct, 64'd0, 2'b00);
        chk("limit hard time", cur_time, ct);
        chk("lock lost", 64'(locked), 64'd0);
        tick(20); chk("no stale steps", cur_time, ct + 64'd66);

        // Limit boundaries: err == max is soft, err == min-1 is hard
        ct = model_now() + 64'd1000;
        send(2'b01, ct, 64'd0, 2'b00);
        chk("max edge soft", 64'(cur_time == ct), 64'd0);
        ct = model_now() - 64'd1001;
        send(2'b01, ct, 64'd0, 2'b00);
        chk("min edge hard", cur_time, ct);

        // Remainder clipped to adjust_max = 2
        adj_max = 32'sd2;
        send(2'b01, ct + 64'd50, 64'd0, 2'b00);
        tick(40); chk("clipped steps", cur_time, ct + 64'd138);
        adj_max = 32'sd1000;

        // set_valid overrides channel samples
        set_valid = 1'b1;
        set_time  = 64'h1234_5678_0000_0000;
        send(2'b11, 64'd5, 64'd9, 2'b00);
        set_valid = 1'b0;
        chk("set_valid time", cur_time, 64'h1234_5678_0000_0000);
        chk("set_valid no drop", 64'(drop), 64'd0);
        chk("set_valid ch_valid", 64'(ch_valid), 64'd0);
        ct = model_now() + 64'd1;
        send(2'b01, ct, 64'd0, 2'b00);
        chk("post-set init hard", cur_time, ct);
        ct = model_now() + 64'd2;
        send(2'b01, ct, 64'd0, 2'b01);
        chk("override hard", cur_time, ct);

        // Modular wrap
        set_valid = 1'b1;
        set_time  = 64'hFFFF_FFFF_FFFF_FFFE;
        tick(1);
        set_valid = 1'b0;
        chk("wrap load", cur_time, 64'hFFFF_FFFF_FFFF_FFFE);
        tick(1); chk("wrap", cur_time, 64'd1);

        // Reset mid-WAIT
        send(2'b01, 64'd500, 64'd0, 2'b00);
        send(2'b11, model_now() + 64'd3, 64'd0, 2'b00);
        tick(5);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("mid reset time", cur_time, 64'd0);
        chk("mid reset drop", 64'(drop), 64'd0);
        chk("mid reset last_error", last_error, 64'd0);
        chk("mid reset ch_valid", 64'(ch_valid), 64'd0);
        tick(20); chk("post reset no steps", cur_time, 64'd66);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
